// File: rtl/fifo_pkg.sv
// Shared widths, depth helper and error codes for the parametrised FIFO family.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 6;
    localparam int unsigned ADDR_WIDTH_DEF = 2;

    // Error codes as seen on {err_underflow, err_overflow}.
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port RAM: synchronous write, registered read; contents are not reset.
// Latency: read data valid one edge after rd_en; a same-address write returns the old word.
// Backpressure: none, every enabled access completes.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with programmable thresholds, occupancy count and error reporting.
// Latency: count/flags update on the accepting edge; read data one edge after pop.
// Backpressure: Pausa asks the producer to stop; pushes into a full FIFO are dropped and flagged.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] Fifo_Data_out,
    output logic [ADDR_WIDTH:0]   Fifo_Count,
    output logic                  Fifo_Empty,
    output logic                  Fifo_Full,
    output logic                  Almost_Empty,
    output logic                  Almost_Full,
    output logic                  Pausa,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic                  Error_Fifo
);

    localparam int unsigned    DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam int unsigned    CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  err_q, err_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign Fifo_Empty   = (count_q == '0);
    assign Fifo_Full    = (count_q == DEPTH_C);
    assign Almost_Empty = (count_q != '0) && (count_q <= umbral_bajo);
    assign Almost_Full  = !Fifo_Full && (count_q >= umbral_alto);
    assign Pausa        = (count_q >= umbral_alto) || Fifo_Full;

    always_comb begin
        pop_ok   = pop && !Fifo_Empty;
        push_ok  = push && (!Fifo_Full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push && !push_ok;
        unf_d    = pop && !pop_ok;
        rd_vld_d = rd_vld_q || pop_ok;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh error in the same cycle takes priority over the clear.
        if (ovf_d || unf_d) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            err_q    <= err_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (Fifo_Data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; masking until the first pop after
    // reset gives a zero output that clears asynchronously with reset_L.
    assign Fifo_Data_out = rd_vld_q ? ram_rd_data : '0;
    assign Fifo_Count    = count_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign Error_Fifo    = err_q;

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: the next-generation buffer for the 6-bit data path, generalised in data width and depth. Adds runtime-programmable almost-empty/almost-full thresholds, an occupancy count, explicit overflow/underflow reporting and defined simultaneous push/pop behaviour at every fill level. It sits between a producer that obeys `Pausa` and a consumer that pops on demand. Storage is a registered-read two-port RAM.

## Interface
- `DATA_WIDTH`, 6, width of each stored word.
- `ADDR_WIDTH`, 2, pointer width; depth `DEPTH = 2**ADDR_WIDTH` (derived, not overridable).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request; `Fifo_Data_in` is captured when the push is accepted.
- `pop`  in  1  read request.
- `Fifo_Data_in`  in  DATA_WIDTH  write data.
- `umbral_bajo`  in  ADDR_WIDTH+1  almost-empty threshold; sampled every cycle.
- `umbral_alto`  in  ADDR_WIDTH+1  almost-full threshold; sampled every cycle.
- `err_clr`  in  1  clears sticky `Error_Fifo`.
- `Fifo_Data_out`  out  DATA_WIDTH  read data, registered.
- `Fifo_Count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `Fifo_Empty`, `Fifo_Full`, `Almost_Empty`, `Almost_Full`, `Pausa`  out  1 each  status flags.
- `err_overflow`, `err_underflow`  out  1 each  one-cycle pulse on each rejected request.
- `Error_Fifo`  out  1  sticky error.

## Operation
- Pointers: `wr_ptr` and `rd_ptr`, each ADDR_WIDTH bits, wrap naturally from DEPTH-1 to 0. Occupancy is held in a `count` register of ADDR_WIDTH+1 bits.
- Acceptance:
  - `push_ok = push & (!Fifo_Full | pop_ok)`.
  - `pop_ok = pop & !Fifo_Empty`.
- Push accepted: write to RAM at `wr_ptr`, then `wr_ptr` +1.
- Pop accepted: RAM reads `rd_ptr`, then `rd_ptr` +1.
- Count update: +1 on push only, −1 on pop only, unchanged when both are accepted or neither is.
- Push and pop when full: both accepted, count stays DEPTH, no overflow.
- Push and pop when empty: push accepted, pop rejected, `err_underflow` pulses, count becomes 1.
- Push when full without pop: data dropped, pointers and count unchanged, `err_overflow` pulses.
- Pop when empty: no pointer change, `Fifo_Data_out` holds its value, `err_underflow` pulses.
- Flags are decoded combinationally from the `count` register, so they are glitch-free with respect to inputs other than the thresholds:
  - `Fifo_Empty = (count == 0)`.
  - `Fifo_Full = (count == DEPTH)`.
  - `Almost_Empty = (count != 0) & (count <= umbral_bajo)`.
  - `Almost_Full = !Fifo_Full & (count >= umbral_alto)`.
  - `Pausa = (count >= umbral_alto) | Fifo_Full`.
- Thresholds outside 0..DEPTH are legal and simply make the corresponding flag never or always assert.
- `Error_Fifo` is set on any overflow or underflow pulse. It is cleared by `err_clr` when no new error occurs in the same cycle; a new error wins over `err_clr`.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): pointers 0, count 0, `Fifo_Data_out` 0, `Error_Fifo` 0, pulses 0.
  - Resulting flags: `Fifo_Empty` 1, all other flags 0, `Pausa` 0 unless `umbral_alto` is 0.
  - Reset mid-operation discards all contents immediately. RAM contents are not cleared.
- Write-to-count latency: count and flags reflect an accepted push or pop after the same rising edge.
- Read latency: 1 cycle. Data for a pop accepted at edge N is valid on `Fifo_Data_out` after edge N and held until the next accepted pop.
- Write-to-read: a word pushed at edge N is poppable from edge N+1 onward; no same-cycle fall-through.
- `err_overflow` and `err_underflow` are registered and high for exactly the cycle after the offending edge. `Error_Fifo` rises at that same time.
- Producer rule: stop pushing within 1 cycle of `Pausa` rising. Headroom is `DEPTH − umbral_alto` words.

## Structure
- Shared package `fifo_pkg`: default widths, a `DEPTH` function of `ADDR_WIDTH`, and the error-code constants (`ERR_NONE`, `ERR_OVF`, `ERR_UNF`) used by testbench checkers.
- One sub-module, `fifo_mem_2p`: parametrised two-port RAM with synchronous write and registered read (ports: clock, write enable, write address, write data, read enable, read address, read data).
- Pointer, count, flag and error logic stays in `fifo_param`.
- Target size: 150–250 lines of RTL in total.

## Test plan
All scenarios use DATA_WIDTH=6, ADDR_WIDTH=2, `umbral_bajo`=1, `umbral_alto`=3.
- Reset, then push 0x01, 0x02, 0x03, 0x04 on consecutive cycles:
  - `Fifo_Count` goes 1, 2, 3, 4.
  - `Almost_Empty` is high only at count 1.
  - `Pausa` rises at count 3; `Fifo_Full` is set at count 4.
  - No errors.
- Fifth push while full → `err_overflow` pulses, `Error_Fifo` is 1, count stays 4. Then pop four times → output 0x01..0x04 in order, each 1 cycle after its pop.
- Pop on an empty FIFO → `err_underflow` pulses, `Fifo_Data_out` unchanged. Assert `err_clr` → `Error_Fifo` returns to 0 the next cycle.
- Simultaneous push/pop:
  - At count 2: count stays 2, FIFO order preserved.
  - At count 4: both accepted, no overflow.
  - At count 0: push accepted, underflow pulses, count becomes 1.
- Wrap-around: run 20 cycles of random push/pop against a reference queue model → data and count match every cycle, including pointer wrap at 3→0.
- Assert `reset_L` low asynchronously between edges while count is 3 → count goes to 0, `Fifo_Empty` goes to 1 and `Fifo_Data_out` goes to 0 immediately, without waiting for a clock edge.
